// File: rtl/fetch_control_if.sv
// rtl/fetch_control_if.sv - instruction memory request/response bundle
interface fetch_control_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    // fetch side issues requests and receives instruction words
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    // memory side accepts requests and returns instruction words
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_control.sv
// rtl/fetch_control.sv - four-state instruction fetch and PC-update decoder
module fetch_control (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic              stall,
    input  logic              br_taken,
    fetch_control_if.master   imem,
    output logic              pc_en,
    output logic [1:0]        func,
    output logic [21:0]       offset,
    output logic [4:0]        rs1,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              illegal
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DECODE = 2'd3
    } state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;
    logic        pc_en_q;
    logic        instr_valid_q;
    logic        illegal_q;
    logic [1:0]  func_q;
    logic [21:0] offset_q;
    logic [4:0]  rs1_q;
    logic [31:0] instr_q;

    logic [1:0]  func_d;
    logic [21:0] offset_d;
    logic [4:0]  rs1_d;
    logic        illegal_d;

    // Decode the word arriving on the read bus so the results can be registered
    // on the same edge that captures it; br_taken is taken from that edge too.
    always_comb begin
        func_d    = 2'b00;
        offset_d  = 22'd0;
        rs1_d     = 5'd0;
        illegal_d = 1'b0;
        if (imem.imem_rdata[1:0] != 2'b11) begin
            illegal_d = 1'b1;
        end else begin
            case (imem.imem_rdata[6:0])
                OP_JAL: begin
                    func_d   = 2'b01;
                    offset_d = {imem.imem_rdata[31], imem.imem_rdata[31],
                                imem.imem_rdata[19:12], imem.imem_rdata[20],
                                imem.imem_rdata[30:21], 1'b0};
                end
                OP_JALR: begin
                    func_d   = 2'b10;
                    rs1_d    = imem.imem_rdata[19:15];
                    offset_d = {{10{imem.imem_rdata[31]}}, imem.imem_rdata[31:20]};
                end
                OP_BRANCH: begin
                    if (br_taken) begin
                        func_d   = 2'b01;
                        offset_d = {{10{imem.imem_rdata[31]}}, imem.imem_rdata[7],
                                    imem.imem_rdata[30:25], imem.imem_rdata[11:8], 1'b0};
                    end
                end
                default: begin
                    func_d = 2'b00;
                end
            endcase
        end
    end

    // Fetch sequencer with registered bus and decode outputs; the pulses only
    // live for the single DECODE cycle and async reset abandons any fetch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= 32'd0;
            pc_en_q       <= 1'b0;
            instr_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            func_q        <= 2'b00;
            offset_q      <= 22'd0;
            rs1_q         <= 5'd0;
            instr_q       <= 32'd0;
        end else begin
            pc_en_q       <= 1'b0;
            instr_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!stall) begin
                        state_q     <= ST_REQ;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc;
                    end
                end
                ST_REQ: begin
                    if (imem.imem_ready) begin
                        state_q    <= ST_WAIT;
                        imem_req_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_rvalid) begin
                        state_q       <= ST_DECODE;
                        instr_q       <= imem.imem_rdata;
                        func_q        <= func_d;
                        offset_q      <= offset_d;
                        rs1_q         <= rs1_d;
                        illegal_q     <= illegal_d;
                        pc_en_q       <= 1'b1;
                        instr_valid_q <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = imem_addr_q;
    assign pc_en          = pc_en_q;
    assign instr_valid    = instr_valid_q;
    assign illegal        = illegal_q;
    assign func           = func_q;
    assign offset         = offset_q;
    assign rs1            = rs1_q;
    assign instr          = instr_q;

endmodule
